// File: rtl/mips_ctrl_pkg.sv
// mips_ctrl_pkg: shared encodings for the multi-cycle MIPS control unit
package mips_ctrl_pkg;

    localparam logic [3:0] S_IDLE     = 4'd0;
    localparam logic [3:0] S_FETCH    = 4'd1;
    localparam logic [3:0] S_DECODE   = 4'd2;
    localparam logic [3:0] S_MEM_ADDR = 4'd3;
    localparam logic [3:0] S_MEM_RD   = 4'd4;
    localparam logic [3:0] S_MEM_WB   = 4'd5;
    localparam logic [3:0] S_MEM_WR   = 4'd6;
    localparam logic [3:0] S_R_EXEC   = 4'd7;
    localparam logic [3:0] S_R_WB     = 4'd8;
    localparam logic [3:0] S_I_EXEC   = 4'd9;
    localparam logic [3:0] S_I_WB     = 4'd10;
    localparam logic [3:0] S_BRANCH   = 4'd11;
    localparam logic [3:0] S_TRAP     = 4'd12;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;

    localparam logic [5:0] F_ADD = 6'b100000;
    localparam logic [5:0] F_SUB = 6'b100010;
    localparam logic [5:0] F_AND = 6'b100100;
    localparam logic [5:0] F_OR  = 6'b100101;
    localparam logic [5:0] F_SLT = 6'b101010;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;

    localparam logic [1:0] ALUB_RT     = 2'b00;
    localparam logic [1:0] ALUB_FOUR   = 2'b01;
    localparam logic [1:0] ALUB_IMM    = 2'b10;
    localparam logic [1:0] ALUB_IMM_SH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;

    // States that stall on the memory handshake and therefore run the wait counter
    function automatic logic is_wait(input logic [3:0] s);
        return (s == S_FETCH) || (s == S_MEM_RD) || (s == S_MEM_WR);
    endfunction

endpackage

// File: rtl/mips_alu_dec.sv
// mips_alu_dec: R-type funct field to ALU operation and legality flag
module mips_alu_dec
    import mips_ctrl_pkg::*;
(
    input  logic [5:0] funct,
    output logic [3:0] alu_ctrl,
    output logic       legal
);

    // Map each supported funct to its ALU code; unknown funct flags illegal
    always_comb begin
        alu_ctrl = (funct == F_ADD) ? ALU_ADD :
                   (funct == F_SUB) ? ALU_SUB :
                   (funct == F_AND) ? ALU_AND :
                   (funct == F_OR)  ? ALU_OR  :
                   (funct == F_SLT) ? ALU_SLT : ALU_AND;
        legal    = (funct == F_ADD) || (funct == F_SUB) || (funct == F_AND) ||
                   (funct == F_OR)  || (funct == F_SLT);
    end

endmodule

// File: rtl/mips_mc_ctrl.sv
// mips_mc_ctrl: multi-cycle MIPS control FSM with memory timeout, sticky status and retire counter
module mips_mc_ctrl
    import mips_ctrl_pkg::*;
#(
    parameter int unsigned CNT_W       = 16,
    parameter int unsigned MEM_TIMEOUT = 15
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [5:0]       opcode,
    input  logic [5:0]       funct,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             pc_write,
    output logic             pc_write_cond,
    output logic             iord,
    output logic             mem_read,
    output logic             mem_write,
    output logic             ir_write,
    output logic             reg_dst,
    output logic             mem_to_reg,
    output logic             reg_write,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [3:0]       alu_ctrl,
    output logic [1:0]       pc_source,
    output logic [7:0]       status,
    output logic [CNT_W-1:0] retired
);

    localparam int unsigned WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'((MEM_TIMEOUT == 0) ? 0 : MEM_TIMEOUT - 1);

    logic [3:0]        state_q, state_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic              illegal_q, illegal_d;
    logic              timeout_q, timeout_d;
    logic              done_q, done_d;
    logic [CNT_W-1:0]  retired_q, retired_d;
    logic [3:0]        r_alu_ctrl;
    logic              r_legal;
    logic              timeout_hit;
    logic              retire;
    logic              unused_zero;

    // zero gates pc_write_cond in the datapath, not here
    assign unused_zero = zero;

    mips_alu_dec u_alu_dec (
        .funct    (funct),
        .alu_ctrl (r_alu_ctrl),
        .legal    (r_legal)
    );

    assign timeout_hit = (MEM_TIMEOUT != 0) && is_wait(state_q) && !mem_ready && (wait_q == WAIT_MAX);
    assign retire      = (state_q == S_MEM_WB) || (state_q == S_R_WB) || (state_q == S_I_WB) ||
                         (state_q == S_BRANCH) || ((state_q == S_MEM_WR) && mem_ready);
    assign status      = {illegal_q, timeout_q, done_q, 1'b0, state_q};
    assign retired     = retired_q;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // Wait counter, sticky flags, retire pulse and counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_q    <= '0;
            illegal_q <= 1'b0;
            timeout_q <= 1'b0;
            done_q    <= 1'b0;
            retired_q <= '0;
        end else begin
            wait_q    <= wait_d;
            illegal_q <= illegal_d;
            timeout_q <= timeout_d;
            done_q    <= done_d;
            retired_q <= retired_d;
        end
    end

    // Next-state sequencing; a memory stall that runs out diverts to TRAP
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:     state_d = S_FETCH;
            S_FETCH:    state_d = mem_ready ? S_DECODE : (timeout_hit ? S_TRAP : S_FETCH);
            S_DECODE: begin
                case (opcode)
                    OP_RTYPE:     state_d = r_legal ? S_R_EXEC : S_TRAP;
                    OP_ADDI:      state_d = S_I_EXEC;
                    OP_LW, OP_SW: state_d = S_MEM_ADDR;
                    OP_BEQ:       state_d = S_BRANCH;
                    default:      state_d = S_TRAP;
                endcase
            end
            S_MEM_ADDR: state_d = (opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
            S_MEM_RD:   state_d = mem_ready ? S_MEM_WB : (timeout_hit ? S_TRAP : S_MEM_RD);
            S_MEM_WR:   state_d = mem_ready ? S_FETCH : (timeout_hit ? S_TRAP : S_MEM_WR);
            S_R_EXEC:   state_d = S_R_WB;
            S_I_EXEC:   state_d = S_I_WB;
            S_MEM_WB, S_R_WB, S_I_WB, S_BRANCH, S_TRAP: state_d = S_FETCH;
            default:    state_d = S_IDLE;
        endcase
    end

    // Bookkeeping next values; illegal latches on any entry into TRAP
    always_comb begin
        wait_d    = (is_wait(state_q) && !mem_ready && !timeout_hit) ? wait_q + WAIT_W'(1) : '0;
        timeout_d = timeout_q | timeout_hit;
        illegal_d = illegal_q | ((state_d == S_TRAP) && (state_q != S_TRAP));
        done_d    = retire;
        retired_d = retired_q + CNT_W'(retire);
    end

    // Moore control decode; fetch load enables also wait for mem_ready
    always_comb begin
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        iord          = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        reg_dst       = 1'b0;
        mem_to_reg    = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = ALUB_RT;
        alu_ctrl      = ALU_AND;
        pc_source     = PCSRC_ALU;
        case (state_q)
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = ALUB_FOUR;
                alu_ctrl  = ALU_ADD;
                pc_write  = mem_ready;
                ir_write  = mem_ready;
            end
            S_DECODE: begin
                alu_src_b = ALUB_IMM_SH;
                alu_ctrl  = ALU_ADD;
            end
            S_MEM_ADDR, S_I_EXEC: begin
                alu_src_a = 1'b1;
                alu_src_b = ALUB_IMM;
                alu_ctrl  = ALU_ADD;
            end
            S_MEM_RD: begin
                mem_read = 1'b1;
                iord     = 1'b1;
            end
            S_MEM_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
            end
            S_MEM_WR: begin
                mem_write = 1'b1;
                iord      = 1'b1;
            end
            S_R_EXEC: begin
                alu_src_a = 1'b1;
                alu_ctrl  = r_alu_ctrl;
            end
            S_R_WB: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
            end
            S_I_WB:     reg_write = 1'b1;
            S_BRANCH: begin
                alu_src_a     = 1'b1;
                alu_ctrl      = ALU_SUB;
                pc_write_cond = 1'b1;
                pc_source     = PCSRC_ALUOUT;
            end
            default: ;
        endcase
    end

endmodule
